filter2d_k3_stream: RTL

- Parametrised successor of the fixed 3x3 streaming image filter.
- Loads nine signed weights through an address/request handshake, then accepts a raster pixel stream.
- Buffers two lines internally and emits one saturated unsigned pixel per complete 3x3 window through a 3-stage MAC pipeline.
- Sits between the frame source and the PE output collector, on a single clock domain.

---
 rtl/filter2d_k3_stream_if.sv | 26 ++
 rtl/filter2d_k3_stream.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/filter2d_k3_stream_if.sv
// Handshake bundle for filter2d_k3_stream: weight load port and pixel in/out streams.
`timescale 1ns/1ps
interface filter2d_k3_stream_if #(
    parameter int BITWIDTH = 8
);
    logic signed [BITWIDTH-1:0] weight_in;
    logic                       weight_in_valid;
    logic [3:0]                 weight_addr;
    logic                       request;
    logic                       ready;
    logic [BITWIDTH-1:0]        data_in;
    logic                       data_in_valid;
    logic [BITWIDTH-1:0]        data_out;
    logic                       data_out_valid;
    logic                       frame_done;

    modport slave (
        input  weight_in, weight_in_valid, data_in, data_in_valid,
        output weight_addr, request, ready, data_out, data_out_valid, frame_done
    );

    modport master (
        output weight_in, weight_in_valid, data_in, data_in_valid,
        input  weight_addr, request, ready, data_out, data_out_valid, frame_done
    );
endinterface

// File: rtl/filter2d_k3_stream.sv
// Streaming 3x3 signed-weight filter: weight LOAD phase, then raster pixels through
// two line buffers and a 3-stage MAC. Define FILTER2D_ABS_EN to fold negative sums to magnitude.
`timescale 1ns/1ps
module filter2d_k3_stream #(
    parameter int BITWIDTH = 8,
    parameter int COLS     = 800,
    parameter int ROWS     = 600,
    parameter int SHIFT    = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic interrupt,
    filter2d_k3_stream_if.slave bus
);
    localparam int PW     = 2*BITWIDTH + 1;
    localparam int SW     = 2*BITWIDTH + 5;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);
    localparam int STAGES = 3;

    typedef enum logic {LOAD = 1'b0, RUN = 1'b1} state_t;

    state_t                     state, state_nxt;
    logic [3:0]                 waddr, waddr_nxt;
    logic signed [BITWIDTH-1:0] weight [9];
    logic                       accept, trig, last;
    logic [CW-1:0]              col;
    logic [RW-1:0]              row;
    logic [BITWIDTH-1:0]        lb0 [COLS];
    logic [BITWIDTH-1:0]        lb1 [COLS];
    logic [BITWIDTH-1:0]        win [3][3];
    logic [STAGES:0]            vld_pipe, last_pipe;
    logic signed [PW-1:0]       prod [9];
    logic signed [SW-1:0]       rsum [3];
    logic signed [SW-1:0]       total, shifted;
    logic signed [SW:0]         mag;
    logic [BITWIDTH-1:0]        clamped, data_out_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
            waddr <= '0;
        end else begin
            state <= state_nxt;
            waddr <= waddr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        waddr_nxt = waddr;
        if (interrupt) begin
            state_nxt = LOAD;
            waddr_nxt = '0;
        end else begin
            case (state)
                LOAD: if (bus.weight_in_valid) begin
                    if (waddr == 4'd8) begin
                        waddr_nxt = '0;
                        state_nxt = RUN;
                    end else begin
                        waddr_nxt = waddr + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.request     = (state == LOAD);
    assign bus.ready       = (state == RUN);
    assign bus.weight_addr = waddr;

    always_ff @(posedge clk) begin
        if (state == LOAD && bus.weight_in_valid && !interrupt)
            weight[waddr] <= bus.weight_in;
    end

    assign accept = (state == RUN) && bus.data_in_valid && !interrupt;
    // c>=2 gating keeps every window inside a single line
    assign trig   = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign last   = trig && (row == RW'(ROWS-1)) && (col == CW'(COLS-1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
        end else if (interrupt) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == CW'(COLS-1)) begin
                col <= '0;
                row <= (row == RW'(ROWS-1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // lb1 holds row r-2, lb0 row r-1; window column 2 is the newest
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.data_in;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= lb1[col];
            win[1][2] <= lb0[col];
            win[2][2] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (interrupt) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], trig};
            last_pipe <= {last_pipe[STAGES-1:0], last};
        end
    end

    always_ff @(posedge clk) begin
        if (vld_pipe[0])
            for (int k = 0; k < 9; k++)
                prod[k] <= PW'($signed({1'b0, win[k/3][k%3]})) * PW'(weight[k]);
        if (vld_pipe[1])
            for (int i = 0; i < 3; i++)
                rsum[i] <= SW'(prod[3*i]) + SW'(prod[3*i+1]) + SW'(prod[3*i+2]);
    end

    always_comb begin
        total   = rsum[0] + rsum[1] + rsum[2];
        shifted = total >>> SHIFT;
        mag     = {shifted[SW-1], shifted};
`ifdef FILTER2D_ABS_EN
        if (shifted[SW-1]) mag = -mag;
`else
        if (shifted[SW-1]) mag = '0;
`endif
        clamped = (|mag[SW:BITWIDTH]) ? '1 : mag[BITWIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            data_out_r <= '0;
        else if (vld_pipe[2] && !interrupt)
            data_out_r <= clamped;
    end

    assign bus.data_out       = data_out_r;
    assign bus.data_out_valid = vld_pipe[STAGES];
    assign bus.frame_done     = last_pipe[STAGES];
endmodule
